writeback_regfile: RTL

- Stage directly downstream of the ALU execute stage. Takes the primary and special ALU results and commits them to the 16-entry, 64-bit architectural register file.
- Provides two combinational read ports to decode, with same-cycle write bypass.
- Keeps a per-register busy scoreboard so decode can detect RAW hazards.
- Runs a halt/drain state machine that replaces the in-ALU simulation stop on RET-class opcodes.

---
 rtl/writeback_regfile.sv | 108 ++++++++++
 1 files changed

// File: rtl/writeback_regfile.sv
// Writeback stage: commits primary/special ALU results to a 16x64 register file,
// provides write-first read ports, a RAW busy scoreboard and a halt/drain FSM.
module writeback_regfile #(
  parameter int NREGS = 16,
  parameter int XLEN  = 64,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [IW-1:0]    wb_dest,
  input  logic [XLEN-1:0]  wb_result,
  input  logic             wb_special_valid,
  input  logic [IW-1:0]    wb_dest_special,
  input  logic [XLEN-1:0]  wb_result_special,
  input  logic             wb_write_en,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [IW-1:0]    iss_dest,
  input  logic [IW-1:0]    iss_dest_special,
  input  logic             iss_dest_en,
  input  logic             iss_dest_special_en,
  input  logic [IW-1:0]    rs1_idx,
  input  logic [IW-1:0]    rs2_idx,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val,
  output logic             rd_hazard,
  input  logic             halt_req,
  output logic             halted,
  output logic [NREGS-1:0] busy_vec
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NREGS-1:0]  clr, set;
  logic              wb_acc, iss_acc, pri_we, sec_we;

  assign wb_ready = (state_q != HALTED);
  assign wb_acc   = wb_valid && wb_ready;
  assign pri_we   = wb_acc && wb_write_en;
  assign sec_we   = wb_acc && wb_special_valid;

  always_comb begin
    clr = '0;
    if (pri_we) clr[wb_dest] = 1'b1;
    if (sec_we) clr[wb_dest_special] = 1'b1;
  end

  assign rd_hazard = (busy_q[rs1_idx] && !clr[rs1_idx]) ||
                     (busy_q[rs2_idx] && !clr[rs2_idx]);
  // Issue is refused the same cycle a halt is requested, not only once in DRAIN.
  assign iss_ready = (state_q == RUN) && !halt_req && !rd_hazard;
  assign iss_acc   = iss_valid && iss_ready;

  always_comb begin
    set = '0;
    if (iss_acc && iss_dest_en)         set[iss_dest] = 1'b1;
    if (iss_acc && iss_dest_special_en) set[iss_dest_special] = 1'b1;
  end

  assign busy_d = (busy_q & ~clr) | set;

  // Secondary first so the primary overwrites it on an index collision.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (sec_we) regs_d[wb_dest_special] = wb_result_special;
    if (pri_we) regs_d[wb_dest] = wb_result;
  end

  always_comb begin
    if (pri_we && wb_dest == rs1_idx)              rs1_val = wb_result;
    else if (sec_we && wb_dest_special == rs1_idx) rs1_val = wb_result_special;
    else                                           rs1_val = regs_q[rs1_idx];
    if (pri_we && wb_dest == rs2_idx)              rs2_val = wb_result;
    else if (sec_we && wb_dest_special == rs2_idx) rs2_val = wb_result_special;
    else                                           rs2_val = regs_q[rs2_idx];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN:   if (busy_d == '0) state_d = HALTED;
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      busy_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign halted   = (state_q == HALTED);
  assign busy_vec = busy_q;

endmodule
